// File: rtl/memory_stage.sv
// Memory stage: 256 x 64-bit data memory behind a valid/ready handshake, one op in flight.
// Optional alignment checking is enabled by defining MISALIGN_CHECK_EN.
module memory_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [63:0] wb_data,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_mem [256];
    logic [7:0]  r_idx;
    logic [63:0] r_wb_data;
    logic        r_misalign;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_is_sd;
    logic        w_is_ld;
    logic [7:0]  w_idx;

    assign w_idx = alu_result[10:3];

`ifdef MISALIGN_CHECK_EN
    assign w_misaligned = (MemRead || MemWrite) && (alu_result[2:0] != 3'b000);
`else
    assign w_misaligned = 1'b0;
`endif

    // Write has priority when both MemRead and MemWrite are set.
    assign w_is_sd  = MemWrite && !w_misaligned;
    assign w_is_ld  = MemRead && !MemWrite && !w_misaligned;
    assign w_accept = valid_in && ready_out && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_is_ld ? READ : DONE;
            READ:    w_next = DONE;
            DONE:    if (ready_in) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (r_state == IDLE);
        valid_out = (r_state == DONE);
        wb_data   = r_wb_data;
        misalign  = valid_out && r_misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_idx      <= w_idx;
            r_misalign <= w_misaligned;
            r_wb_data  <= w_misaligned ? '0 : alu_result;
        end else if (r_state == READ) begin
            r_wb_data  <= r_mem[r_idx];
        end
    end

    // Memory array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_sd) begin
            r_mem[w_idx] <= write_data;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized ops against
// an array-based reference memory. Define MISALIGN_CHECK_EN to match an RTL build with it.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [63:0] alu_result;
    logic [63:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic        valid_out;
    logic        ready_in;
    logic [63:0] wb_data;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model [256];

    memory_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .alu_result (alu_result),
        .write_data (write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .wb_data    (wb_data),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Idle inputs carry garbage that must be ignored when no accept happens.
    task automatic drive_garbage();
        valid_in   = 1'b0;
        MemRead    = 1'($urandom);
        MemWrite   = 1'b1;
        alu_result = {$urandom, $urandom};
        write_data = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int index_of(input logic [63:0] addr);
        return int'((addr % 64'd2048) / 64'd8);
    endfunction

    function automatic bit is_mis(input logic rd, input logic wr, input logic [63:0] addr);
`ifdef MISALIGN_CHECK_EN
        return (rd || wr) && (addr % 64'd8 != 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 20 && ready_out !== 1'b1; k++) step();
        chk1($sformatf("%s/ready_out", tag), ready_out, 1'b1);
    endtask

    // One full transaction: accept, latency, hold with ready_in=0, handshake.
    task automatic do_op(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input int unsigned hold, input string tag);
        bit          mis;
        int          idx;
        int          lat;
        logic [63:0] exp_wb;
        idx = index_of(addr);
        mis = is_mis(rd, wr, addr);
        if (mis)           exp_wb = '0;
        else if (wr)       exp_wb = addr;
        else if (rd)       exp_wb = model[idx];
        else               exp_wb = addr;
        lat = (rd && !wr && !mis) ? 2 : 1;

        wait_ready(tag);
        valid_in   = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        alu_result = addr;
        write_data = data;
        step();
        drive_garbage();
        if (wr && !mis) model[idx] = data;

        if (lat == 2) begin
            chk1($sformatf("%s/valid_lat1", tag), valid_out, 1'b0);
            step();
        end
        chk1($sformatf("%s/valid_out", tag), valid_out, 1'b1);
        chk ($sformatf("%s/wb_data", tag), wb_data, exp_wb);
        chk1($sformatf("%s/misalign", tag), misalign, mis);
        chk1($sformatf("%s/ready_busy", tag), ready_out, 1'b0);
        for (int unsigned h = 0; h < hold; h++) begin
            step();
            chk1($sformatf("%s/hold_valid", tag), valid_out, 1'b1);
            chk ($sformatf("%s/hold_wb", tag), wb_data, exp_wb);
            chk1($sformatf("%s/hold_mis", tag), misalign, mis);
            chk1($sformatf("%s/hold_ready", tag), ready_out, 1'b0);
        end
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;
        chk1($sformatf("%s/post_valid", tag), valid_out, 1'b0);
        chk1($sformatf("%s/post_ready", tag), ready_out, 1'b1);
        chk1($sformatf("%s/post_mis", tag), misalign, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        ready_in = 1'b0;
        drive_garbage();
        #3;
        chk1("reset/valid_out", valid_out, 1'b0);
        chk ("reset/wb_data", wb_data, 64'd0);
        chk1("reset/misalign", misalign, 1'b0);
        chk1("reset/ready_out", ready_out, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Give every word a known value.
        for (int i = 0; i < 256; i++)
            do_op(1'b0, 1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 0, "init");

        do_op(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, "sd_0x10");
        do_op(1'b1, 1'b0, 64'h10, 64'h0, 0, "ld_0x10");
        chk("ld_0x10/value", wb_data, 64'hDEADBEEF_CAFEF00D);

        do_op(1'b0, 1'b0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 0, "alu_0x1234");
        do_op(1'b1, 1'b0, 64'h1234, 64'h0, 0, "alu_mem_unchanged");

        do_op(1'b1, 1'b0, 64'h10, 64'h0, 4, "ld_hold4");

        do_op(1'b0, 1'b1, 64'h800, 64'h5, 0, "sd_wrap");
        do_op(1'b1, 1'b0, 64'h0, 64'h0, 0, "ld_wrap");
        chk("ld_wrap/value", wb_data, 64'h5);

        do_op(1'b1, 1'b1, 64'h48, 64'h0123_4567_89AB_CDEF, 1, "rdwr_is_sd");
        do_op(1'b1, 1'b0, 64'h48, 64'h0, 0, "rdwr_check");

        // Reset during READ aborts the load; memory survives.
        do_op(1'b0, 1'b1, 64'h40, 64'hA5A5_5A5A_0F0F_F0F0, 0, "sd_pre_reset");
        wait_ready("rst_ld");
        valid_in   = 1'b1;
        MemRead    = 1'b1;
        MemWrite   = 1'b0;
        alu_result = 64'h40;
        step();
        drive_garbage();
        chk1("rst_mid/in_read", valid_out, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid/valid_out", valid_out, 1'b0);
        chk ("rst_mid/wb_data", wb_data, 64'd0);
        chk1("rst_mid/ready_out", ready_out, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk1("rst_mid/no_valid", valid_out, 1'b0);
        end
        do_op(1'b1, 1'b0, 64'h40, 64'h0, 0, "ld_after_reset");
        chk("ld_after_reset/value", wb_data, 64'hA5A5_5A5A_0F0F_F0F0);

        // Misaligned access: rejected with the macro, silently aligned without it.
        do_op(1'b0, 1'b1, 64'h13, 64'h1111_2222_3333_4444, 0, "sd_0x13");
        do_op(1'b1, 1'b0, 64'h10, 64'h0, 0, "ld_0x10_after_mis");
        do_op(1'b1, 1'b0, 64'h13, 64'h0, 2, "ld_0x13");

        for (int r = 0; r < 60; r++) begin
            logic [63:0] a;
            logic        rd;
            logic        wr;
            a  = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[2:0] = 3'b000;
            rd = 1'($urandom);
            wr = 1'($urandom);
            repeat ($urandom_range(2)) step();
            do_op(rd, wr, a, {$urandom, $urandom}, $urandom_range(2), $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
